// File: rtl/instr_loader.sv
// Instruction RAM loader: streams a length-prefixed little-endian program into RAM port C.
// Optional trailing XOR checksum byte when INSTR_LOADER_CHECKSUM_EN is defined.
module instr_loader #(
    parameter int unsigned WIDTH_INSTR = 8,
    parameter int unsigned WIDTH_ADDR  = 8,
    parameter int unsigned HDR_BYTES   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   wec,
    output logic [WIDTH_ADDR-1:0]  addrc,
    output logic [WIDTH_INSTR-1:0] dinc,
    output logic                   core_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [WIDTH_ADDR-1:0]  count
);

    localparam int unsigned Bpi  = WIDTH_INSTR / 8;
    localparam int unsigned HdrW = 8 * HDR_BYTES;

    typedef enum logic [2:0] {StIdle, StHdr, StData, StWrite, StFin, StCsum} state_e;

    state_e                 state_q, state_d;
    logic [7:0]             idx_q, idx_d;
    logic [HdrW-1:0]        hdr_q, hdr_d;
    logic [WIDTH_INSTR-1:0] word_q, word_d;
    logic [WIDTH_ADDR-1:0]  count_q, count_d;
    logic [WIDTH_ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH_INSTR-1:0] dout_q, dout_d;
    logic                   xfer;

    // Bytes enter at the top and shift down, so byte 0 ends up in the low lane.
    logic [HdrW+7:0]        hdr_cat;
    logic [WIDTH_INSTR+7:0] word_cat;
    logic [HdrW-1:0]        hdr_shift;
    logic [WIDTH_INSTR-1:0] word_shift;

    assign hdr_cat    = {s_data, hdr_q};
    assign word_cat   = {s_data, word_q};
    assign hdr_shift  = hdr_cat[HdrW+7:8];
    assign word_shift = word_cat[WIDTH_INSTR+7:8];

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic       err_q, err_d;
    logic [7:0] csum_q, csum_d;
    localparam state_e StAfterLast = StCsum;
    assign err = err_q;
`else
    localparam state_e StAfterLast = StFin;
    assign err = 1'b0;
`endif

    assign s_ready   = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);
    assign xfer      = s_valid && s_ready;
    assign wec       = (state_q == StWrite);
    assign busy      = (state_q == StHdr) || (state_q == StData) || (state_q == StWrite)
                    || (state_q == StCsum);
    assign core_hold = busy;
    assign done      = (state_q == StFin);
    assign addrc     = addr_q;
    assign dinc      = dout_q;
    assign count     = count_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hdr_d   = hdr_q;
        word_d  = word_q;
        count_d = count_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        err_d   = err_q;
        csum_d  = csum_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StHdr;
                    idx_d   = '0;
                    count_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
                    csum_d  = '0;
`endif
                end
            end
            StHdr: begin
                if (xfer) begin
                    hdr_d = hdr_shift;
                    idx_d = idx_q + 8'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ s_data;
`endif
                    if (idx_q == 8'(HDR_BYTES - 1)) begin
                        idx_d   = '0;
                        state_d = (hdr_shift[WIDTH_ADDR-1:0] == '0) ? StAfterLast : StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    word_d = word_shift;
                    idx_d  = idx_q + 8'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ s_data;
`endif
                    if (idx_q == 8'(Bpi - 1)) begin
                        idx_d   = '0;
                        addr_d  = count_q;
                        dout_d  = word_shift;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                count_d = count_q + 1'b1;
                state_d = (count_d == hdr_q[WIDTH_ADDR-1:0]) ? StAfterLast : StData;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            StCsum: begin
                if (xfer) begin
                    err_d   = (s_data != csum_q);
                    state_d = StFin;
                end
            end
`endif
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            hdr_q   <= '0;
            word_q  <= '0;
            count_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            err_q   <= 1'b0;
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hdr_q   <= hdr_d;
            word_q  <= word_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            err_q   <= err_d;
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: 8-bit and 16-bit word instances on one clock and reset.
module tb_instr_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b, s_valid, sel;
    logic [7:0] s_data;

    logic       s_ready_a, wec_a, core_hold_a, busy_a, done_a, err_a;
    logic [7:0] addrc_a, dinc_a, count_a;
    logic       s_ready_b, wec_b, core_hold_b, busy_b, done_b, err_b;
    logic [7:0] addrc_b, count_b;
    logic [15:0] dinc_b;

    int checks = 0;
    int errors = 0;
    int wr_a   = 0;
    logic [7:0] mem_a [0:255];

    instr_loader #(.WIDTH_INSTR(8), .WIDTH_ADDR(8), .HDR_BYTES(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .s_data(s_data), .s_valid(s_valid && !sel),
        .s_ready(s_ready_a), .wec(wec_a), .addrc(addrc_a), .dinc(dinc_a),
        .core_hold(core_hold_a), .busy(busy_a), .done(done_a), .err(err_a), .count(count_a)
    );

    instr_loader #(.WIDTH_INSTR(16), .WIDTH_ADDR(8), .HDR_BYTES(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .s_data(s_data), .s_valid(s_valid && sel),
        .s_ready(s_ready_b), .wec(wec_b), .addrc(addrc_b), .dinc(dinc_b),
        .core_hold(core_hold_b), .busy(busy_b), .done(done_b), .err(err_b), .count(count_b)
    );

    // RAM model for instance A, written from the pre-edge port C values.
    always @(posedge clk) begin
        if (wec_a) begin
            mem_a[addrc_a] <= dinc_a;
            wr_a <= wr_a + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (((sel ? s_ready_b : s_ready_a) !== 1'b1) && n < 20) begin
            step();
            n++;
        end
        chk("send_ready", 32'(sel ? s_ready_b : s_ready_a), 'h1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; s_valid = 1'b0; sel = 1'b0; s_data = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_s_ready", 32'(s_ready_a), 'h0);
        chk("rst_wec", 32'(wec_a), 'h0);
        chk("rst_core_hold", 32'(core_hold_a), 'h0);
        chk("rst_busy", 32'(busy_a), 'h0);
        chk("rst_done", 32'(done_a), 'h0);
        chk("rst_err", 32'(err_a), 'h0);
        chk("rst_addrc", 32'(addrc_a), 'h0);
        chk("rst_dinc", 32'(dinc_a), 'h0);
        chk("rst_count", 32'(count_a), 'h0);

        // Happy path: 03, A1, B2, C3
        pulse_start();
        chk("hp_busy", 32'(busy_a), 'h1);
        chk("hp_hold", 32'(core_hold_a), 'h1);
        chk("hp_ready_hdr", 32'(s_ready_a), 'h1);
        send(8'h03);
        send(8'hA1);
        chk("hp_wec0", 32'(wec_a), 'h1);
        chk("hp_addr0", 32'(addrc_a), 'h0);
        chk("hp_din0", 32'(dinc_a), 'hA1);
        chk("hp_ready_wr", 32'(s_ready_a), 'h0);
        send(8'hB2);
        chk("hp_addr1", 32'(addrc_a), 'h1);
        chk("hp_din1", 32'(dinc_a), 'hB2);
        send(8'hC3);
        chk("hp_wec2", 32'(wec_a), 'h1);
        chk("hp_addr2", 32'(addrc_a), 'h2);
        chk("hp_din2", 32'(dinc_a), 'hC3);
        chk("hp_hold_wr", 32'(core_hold_a), 'h1);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(8'hD3);
`else
        step();
`endif
        chk("hp_done", 32'(done_a), 'h1);
        chk("hp_busy_fin", 32'(busy_a), 'h0);
        chk("hp_hold_fin", 32'(core_hold_a), 'h0);
        chk("hp_count", 32'(count_a), 'h3);
        chk("hp_err", 32'(err_a), 'h0);
        step();
        chk("hp_done_low", 32'(done_a), 'h0);
        chk("hp_count_hold", 32'(count_a), 'h3);
        chk("hp_addr_hold", 32'(addrc_a), 'h2);
        chk("hp_din_hold", 32'(dinc_a), 'hC3);
        chk("hp_mem0", 32'(mem_a[0]), 'hA1);
        chk("hp_mem1", 32'(mem_a[1]), 'hB2);
        chk("hp_mem2", 32'(mem_a[2]), 'hC3);
        chk("hp_writes", 32'(wr_a), 'h3);

        // Zero length
        pulse_start();
        send(8'h00);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        chk("z_done", 32'(done_a), 'h1);
        chk("z_count", 32'(count_a), 'h0);
        chk("z_writes", 32'(wr_a), 'h3);
        step();
        chk("z_done_low", 32'(done_a), 'h0);

        // Gaps and a start pulse mid-session
        pulse_start();
        send(8'h02);
        step(); step(); step();
        send(8'h11);
        chk("g_addr0", 32'(addrc_a), 'h0);
        chk("g_din0", 32'(dinc_a), 'h11);
        step();
        pulse_start();
        chk("g_busy", 32'(busy_a), 'h1);
        chk("g_count", 32'(count_a), 'h1);
        step(); step();
        send(8'h22);
        chk("g_addr1", 32'(addrc_a), 'h1);
        chk("g_din1", 32'(dinc_a), 'h22);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(8'h31);
`else
        step();
`endif
        chk("g_done", 32'(done_a), 'h1);
        chk("g_count_end", 32'(count_a), 'h2);
        step();
        chk("g_mem0", 32'(mem_a[0]), 'h11);
        chk("g_mem1", 32'(mem_a[1]), 'h22);
        chk("g_mem2", 32'(mem_a[2]), 'hC3);

`ifdef INSTR_LOADER_CHECKSUM_EN
        pulse_start();
        send(8'h02); send(8'h10); send(8'h20); send(8'h32);
        chk("cs_ok_done", 32'(done_a), 'h1);
        chk("cs_ok_err", 32'(err_a), 'h0);
        step();
        pulse_start();
        send(8'h02); send(8'h10); send(8'h20); send(8'h33);
        chk("cs_bad_done", 32'(done_a), 'h1);
        chk("cs_bad_err", 32'(err_a), 'h1);
        step();
        chk("cs_err_sticky", 32'(err_a), 'h1);
        pulse_start();
        chk("cs_err_clear", 32'(err_a), 'h0);
        send(8'h00); send(8'h00);
        step();
`else
        chk("no_cs_err", 32'(err_a), 'h0);
`endif

        // 16-bit words on instance B: 02, 34 12, 78 56
        sel = 1'b1;
        pulse_start();
        send(8'h02);
        send(8'h34);
        send(8'h12);
        chk("w_wec0", 32'(wec_b), 'h1);
        chk("w_addr0", 32'(addrc_b), 'h0);
        chk("w_din0", 32'(dinc_b), 'h1234);
        chk("w_ready_bubble", 32'(s_ready_b), 'h0);
        step();
        chk("w_ready_back", 32'(s_ready_b), 'h1);
        send(8'h78);
        send(8'h56);
        chk("w_addr1", 32'(addrc_b), 'h1);
        chk("w_din1", 32'(dinc_b), 'h5678);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(8'h0A);
`else
        step();
`endif
        chk("w_done", 32'(done_b), 'h1);
        chk("w_count", 32'(count_b), 'h2);
        step();

        // Reset after one word and half of the next
        pulse_start();
        send(8'h04);
        send(8'h11);
        send(8'h22);
        chk("r_din0", 32'(dinc_b), 'h2211);
        send(8'h33);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("r_busy", 32'(busy_b), 'h0);
        chk("r_hold", 32'(core_hold_b), 'h0);
        chk("r_ready", 32'(s_ready_b), 'h0);
        chk("r_count", 32'(count_b), 'h0);
        chk("r_addr", 32'(addrc_b), 'h0);
        chk("r_din", 32'(dinc_b), 'h0);
        chk("r_wec", 32'(wec_b), 'h0);

        // Fresh session after reset
        pulse_start();
        send(8'h01);
        send(8'hCD);
        send(8'hAB);
        chk("f_wec", 32'(wec_b), 'h1);
        chk("f_addr", 32'(addrc_b), 'h0);
        chk("f_din", 32'(dinc_b), 'hABCD);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(8'h67);
`else
        step();
`endif
        chk("f_done", 32'(done_b), 'h1);
        chk("f_count", 32'(count_b), 'h1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
